// File: rtl/key_sched_pkg.sv
// key_sched_pkg
// Shared definitions for the key schedule sequencer and the locked b01-class
// cores it feeds.
//   - state_e          : sequencer FSM encoding (also exported on state_dbg)
//   - KEY_W_DEF        : default key word width (keyinput0..keyinput2)
//   - NUM_KEYS_DEF     : default number of schedule slots (2**CNT_W_DEF)
//   - CORE_PHASE_W     : width of the core's free-running phase counter
package key_sched_pkg;

    // Single source for the core phase width, so that the locked cores and
    // the sequencer count phases identically.
    localparam int CORE_PHASE_W = 2;

    localparam int KEY_W_DEF    = 3;
    localparam int CNT_W_DEF    = CORE_PHASE_W;
    localparam int NUM_KEYS_DEF = 2 ** CNT_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } state_e;

endpackage

// File: rtl/key_slot_regfile.sv
// key_slot_regfile
// NUM_KEYS x KEY_W slot storage for the key schedule.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (all slots -> 0)
//   we_i, waddr_i, wdata_i : single write port
//   clr_i         : synchronous clear of every slot; a write in the same
//                   cycle takes priority for its own slot
//   raddr_i, rdata_o : combinational read port, indexed by phase
import key_sched_pkg::*;

module key_slot_regfile #(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [CNT_W-1:0] waddr_i,
    input  logic [KEY_W-1:0] wdata_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] raddr_i,
    output logic [KEY_W-1:0] rdata_o
);

    logic [KEY_W-1:0] slot_q [NUM_KEYS];
    logic [KEY_W-1:0] slot_d [NUM_KEYS];

    // Clear first, then write: a fresh load started from READY wipes the old
    // schedule and stores its first beat in slot0 in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            slot_d[i] = clr_i ? '0 : slot_q[i];
        end
        if (we_i) begin
            slot_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign rdata_o = slot_q[raddr_i];

endmodule

// File: rtl/key_schedule_sequencer.sv
// key_schedule_sequencer
// Loads a NUM_KEYS-word key schedule over a valid/ready port and, while armed,
// replays one slot per clock onto a locked core's keyinput bus together with
// the matching phase (0,1,2,3,0,...).
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   load_valid/load_ready : load handshake
//   load_data, load_last  : key word, final-beat marker
//   arm                   : level, high = replay schedule
//   armed                 : high while in RUN
//   keyinput, key_phase   : registered key word and its phase
//   err                   : sticky framing error
//   state_dbg             : current FSM state (state_e encoding)
//
// Handshake: a beat transfers on a rising clock edge where load_valid and
// load_ready are both high; load_data/load_last are ignored otherwise, and
// load_ready does not depend on load_valid.
import key_sched_pkg::*;

module key_schedule_sequencer #(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [KEY_W-1:0] load_data,
    input  logic             load_last,
    input  logic             arm,
    output logic             armed,
    output logic [KEY_W-1:0] keyinput,
    output logic [CNT_W-1:0] key_phase,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             slot_we;
    logic             slot_clr;
    logic [CNT_W-1:0] slot_waddr;
    logic [CNT_W-1:0] rd_addr;
    logic [KEY_W-1:0] rd_data;

    assign accept = load_valid & ready_q;

    // Read the slot for the phase that will be presented next cycle: slot0 on
    // entry to RUN, phase+1 (wrapping) while running.
    assign rd_addr = (state_q == RUN) ? phase_q + ONE : '0;

    key_slot_regfile #(
        .KEY_W    (KEY_W),
        .NUM_KEYS (NUM_KEYS),
        .CNT_W    (CNT_W)
    ) u_slots (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .we_i    (slot_we),
        .waddr_i (slot_waddr),
        .wdata_i (load_data),
        .clr_i   (slot_clr),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        phase_d    = '0;
        key_d      = '0;
        slot_we    = 1'b0;
        slot_clr   = 1'b0;
        slot_waddr = cnt_q;

        unique case (state_q)
            IDLE, READY: begin
                if (accept) begin
                    // First beat of a schedule; from READY the previous
                    // schedule is discarded in the same cycle.
                    slot_we    = 1'b1;
                    slot_waddr = '0;
                    slot_clr   = (state_q == READY);
                    err_d      = 1'b0;
                    if (NUM_KEYS == 1 && load_last) begin
                        cnt_d   = '0;
                        state_d = READY;
                    end else begin
                        cnt_d   = ONE;
                        state_d = LOAD;
                    end
                end else if (state_q == READY && arm) begin
                    key_d   = rd_data;
                    phase_d = '0;
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == LAST_IDX && load_last) begin
                        slot_we = 1'b1;
                        cnt_d   = '0;
                        state_d = READY;
                    end else if (cnt_q == LAST_IDX || load_last) begin
                        // Framing error: schedule too short or too long.
                        err_d    = 1'b1;
                        slot_clr = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        slot_we = 1'b1;
                        cnt_d   = cnt_q + ONE;
                    end
                end
            end
            RUN: begin
                if (arm) begin
                    phase_d = phase_q + ONE;
                    key_d   = rd_data;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            key_q   <= key_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign load_ready = ready_q;
    assign armed      = (state_q == RUN);
    assign keyinput   = key_q;
    assign key_phase  = phase_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// tb_key_schedule_sequencer
// Self-checking bench for key_schedule_sequencer: a table of per-cycle vectors
// for the basic load/run flow, hand-written sequences for the multi-cycle
// corners, and an expected queue for the replayed key stream.
import key_sched_pkg::*;

module tb_key_schedule_sequencer;

    localparam int KEY_W    = 3;
    localparam int NUM_KEYS = 4;
    localparam int CNT_W    = 2;

    logic             clock;
    logic             reset_n;
    logic             load_valid;
    logic             load_ready;
    logic [KEY_W-1:0] load_data;
    logic             load_last;
    logic             arm;
    logic             armed;
    logic [KEY_W-1:0] keyinput;
    logic [CNT_W-1:0] key_phase;
    logic             err;
    logic [1:0]       state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [KEY_W+CNT_W-1:0] exp_q[$];
    logic [KEY_W-1:0]       model_slots [NUM_KEYS];

    key_schedule_sequencer #(
        .KEY_W    (KEY_W),
        .NUM_KEYS (NUM_KEYS),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .arm        (arm),
        .armed      (armed),
        .keyinput   (keyinput),
        .key_phase  (key_phase),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic rdy,
                              input logic er, input logic arm_o,
                              input logic [KEY_W-1:0] key, input logic [CNT_W-1:0] ph);
        check({tag, "_state"}, state_dbg, st);
        check({tag, "_ready"}, load_ready, rdy);
        check({tag, "_err"}, err, er);
        check({tag, "_armed"}, armed, arm_o);
        check({tag, "_key"}, keyinput, key);
        check({tag, "_phase"}, key_phase, ph);
    endtask

    task automatic check_slots(input string tag, input logic [KEY_W-1:0] s0,
                               input logic [KEY_W-1:0] s1, input logic [KEY_W-1:0] s2,
                               input logic [KEY_W-1:0] s3);
        check({tag, "_slot0"}, dut.u_slots.slot_q[0], s0);
        check({tag, "_slot1"}, dut.u_slots.slot_q[1], s1);
        check({tag, "_slot2"}, dut.u_slots.slot_q[2], s2);
        check({tag, "_slot3"}, dut.u_slots.slot_q[3], s3);
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [KEY_W-1:0] d, input logic l, input logic a);
        load_valid = v;
        load_data  = v ? d : 'x;
        load_last  = l;
        arm        = a;
        @(posedge clock);
        #1;
    endtask

    task automatic load_full(input logic [KEY_W-1:0] w0, input logic [KEY_W-1:0] w1,
                             input logic [KEY_W-1:0] w2, input logic [KEY_W-1:0] w3);
        model_slots[0] = w0;
        model_slots[1] = w1;
        model_slots[2] = w2;
        model_slots[3] = w3;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cyc(1'b1, model_slots[i], (i == NUM_KEYS - 1), 1'b0);
        end
    endtask

    // Arm from READY for n cycles; the expected key/phase stream is pushed as
    // arm is driven and popped when the registered output appears.
    task automatic run_sched(input int n);
        logic [KEY_W+CNT_W-1:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({model_slots[i % NUM_KEYS], CNT_W'(i % NUM_KEYS)});
            cyc(1'b0, '0, 1'b0, 1'b1);
            e = exp_q.pop_front();
            check("run_key", keyinput, e[KEY_W+CNT_W-1:CNT_W]);
            check("run_phase", key_phase, e[CNT_W-1:0]);
            check("run_armed", armed, 1'b1);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             v;
        logic [KEY_W-1:0] d;
        logic             l;
        logic             a;
        logic [1:0]       st;
        logic             rdy;
        logic             er;
        logic             arm_o;
        logic [KEY_W-1:0] key;
        logic [CNT_W-1:0] ph;
    } vec_t;

    vec_t vecs [10];

    initial begin
        //        v     d       l     a      state  rdy   err   armed  key     ph
        vecs[0] = '{1'b1, 3'b111, 1'b0, 1'b0, LOAD,  1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
        vecs[1] = '{1'b1, 3'b011, 1'b0, 1'b0, LOAD,  1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
        vecs[2] = '{1'b1, 3'b101, 1'b0, 1'b0, LOAD,  1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
        vecs[3] = '{1'b1, 3'b110, 1'b1, 1'b0, READY, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0};
        vecs[4] = '{1'b0, 3'b000, 1'b0, 1'b1, RUN,   1'b0, 1'b0, 1'b1, 3'b111, 2'd0};
        vecs[5] = '{1'b0, 3'b000, 1'b0, 1'b1, RUN,   1'b0, 1'b0, 1'b1, 3'b011, 2'd1};
        vecs[6] = '{1'b0, 3'b000, 1'b0, 1'b1, RUN,   1'b0, 1'b0, 1'b1, 3'b101, 2'd2};
        vecs[7] = '{1'b0, 3'b000, 1'b0, 1'b1, RUN,   1'b0, 1'b0, 1'b1, 3'b110, 2'd3};
        vecs[8] = '{1'b0, 3'b000, 1'b0, 1'b1, RUN,   1'b0, 1'b0, 1'b1, 3'b111, 2'd0};
        vecs[9] = '{1'b0, 3'b000, 1'b0, 1'b0, READY, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0};

        // ---------------- reset ----------------
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        arm        = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset", IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0);
        check_slots("reset", 3'b000, 3'b000, 3'b000, 3'b000);
        #3 reset_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_outs("idle", IDLE, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);

        // ---------------- table: load 111,011,101,110 then run ----------------
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].a);
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rdy, vecs[i].er,
                       vecs[i].arm_o, vecs[i].key, vecs[i].ph);
        end
        model_slots[0] = 3'b111;
        model_slots[1] = 3'b011;
        model_slots[2] = 3'b101;
        model_slots[3] = 3'b110;

        // ---------------- drop arm after phase 2, then re-arm ----------------
        run_sched(3);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_outs("drop", READY, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        run_sched(5);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_outs("drop2", READY, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);

        // ---------------- arm and load together in READY ----------------
        cyc(1'b1, 3'b010, 1'b0, 1'b1);
        check_outs("collide", LOAD, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        check_slots("collide", 3'b010, 3'b000, 3'b000, 3'b000);

        // ---------------- early load_last on beat 1 ----------------
        cyc(1'b1, 3'b001, 1'b1, 1'b0);
        check_outs("early", IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0);
        check_slots("early", 3'b000, 3'b000, 3'b000, 3'b000);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check_outs("err_sticky", IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0);

        // ---------------- throttled load, clears err on first beat ----------------
        model_slots[0] = 3'b101;
        model_slots[1] = 3'b010;
        model_slots[2] = 3'b100;
        model_slots[3] = 3'b001;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cyc(1'b1, model_slots[i], (i == NUM_KEYS - 1), 1'b0);
            check($sformatf("thr_beat%0d_err", i), err, 1'b0);
            check($sformatf("thr_beat%0d_state", i), state_dbg,
                  (i == NUM_KEYS - 1) ? READY : LOAD);
            if (i != NUM_KEYS - 1) begin
                cyc(1'b0, '0, 1'b0, 1'b0);
                check($sformatf("thr_gap%0d_state", i), state_dbg, LOAD);
            end
        end
        check_slots("thr", 3'b101, 3'b010, 3'b100, 3'b001);
        run_sched(6);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_outs("thr_stop", READY, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);

        // ---------------- missing load_last, arm ignored in LOAD ----------------
        cyc(1'b1, 3'b011, 1'b0, 1'b0);
        check_outs("nolast0", LOAD, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        cyc(1'b1, 3'b100, 1'b0, 1'b1);
        check_outs("nolast1", LOAD, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        cyc(1'b1, 3'b110, 1'b0, 1'b1);
        check_outs("nolast2", LOAD, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        cyc(1'b1, 3'b001, 1'b0, 1'b0);
        check_outs("nolast3", IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0);
        check_slots("nolast", 3'b000, 3'b000, 3'b000, 3'b000);

        // ---------------- async reset mid-RUN ----------------
        load_full(3'b001, 3'b110, 3'b011, 3'b111);
        check_outs("reload", READY, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
        run_sched(2);
        #3 reset_n = 1'b0;
        #1;
        check_outs("async_rst", IDLE, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0);
        check_slots("async_rst", 3'b000, 3'b000, 3'b000, 3'b000);
        @(posedge clock);
        #4 reset_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_outs("post_rst", IDLE, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);

        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
